// File: rtl/fw_interface_master.sv
// fw_interface_master: Wishbone classic single-cycle bus initiator.
//
// Takes one read or write at a time on a valid/ready command port, runs the
// Wishbone cycle, retries after rty (with a one-cycle gap between attempts),
// aborts an attempt that sees no termination within TIMEOUT cycles, and
// returns read data plus a completion status on a valid/ready response port.
//
// Parameters:
//   TIMEOUT    cycles an attempt may wait for ack/err/rty (2..65535)
//   MAX_RETRY  extra attempts allowed after rty (0 = single attempt)
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   cmd_valid_i/cmd_ready_o     command handshake
//   cmd_we_i/adr_i/dat_i/sel_i  command fields
//   rsp_valid_o/rsp_ready_i     response handshake
//   rsp_dat_o                   read data (0 for writes and failures)
//   rsp_status_o                0 OK, 1 ERR, 2 RETRY_EXHAUSTED, 3 TIMEOUT
//   rsp_retries_o               rty terminations seen (saturates at 255)
//   wb_*_o / wb_*_i             Wishbone initiator signals
module fw_interface_master #(
  parameter int unsigned TIMEOUT   = 256,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // Command port
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  // Response port
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic [1:0]  rsp_status_o,
  output logic [7:0]  rsp_retries_o,
  // Wishbone initiator
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic [2:0]  wb_cti_o,
  output logic [1:0]  wb_bte_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i
);

  localparam logic [1:0] StatusOk      = 2'd0;
  localparam logic [1:0] StatusErr     = 2'd1;
  localparam logic [1:0] StatusRtyExh  = 2'd2;
  localparam logic [1:0] StatusTimeout = 2'd3;

  // Last timeout-counter value of an attempt; the counter starts at 0 in the
  // first bus cycle, so aborting here holds cyc/stb for exactly TIMEOUT cycles.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBus, StBackoff, StResp} state_e;

  state_e      state_q;
  logic [15:0] tmo_q;
  logic [7:0]  retry_q;

  logic [7:0]  retry_inc;
  logic        retry_allowed;
  logic        bus_active;

  assign wb_cti_o = 3'b000;
  assign wb_bte_o = 2'b00;

  always_comb begin
    retry_inc     = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
    retry_allowed = ({24'd0, retry_inc} <= MAX_RETRY);
    // Terminations only count while the cycle is actually on the bus.
    bus_active    = wb_cyc_o & wb_stb_o;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= StIdle;
      tmo_q         <= 16'd0;
      retry_q       <= 8'd0;
      cmd_ready_o   <= 1'b0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= 32'd0;
      rsp_status_o  <= StatusOk;
      rsp_retries_o <= 8'd0;
      wb_adr_o      <= 32'd0;
      wb_dat_o      <= 32'd0;
      wb_sel_o      <= 4'd0;
      wb_we_o       <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Registered ready: low on the first edge after reset release.
          cmd_ready_o <= 1'b1;
          if (cmd_valid_i && cmd_ready_o) begin
            wb_we_o     <= cmd_we_i;
            wb_adr_o    <= cmd_adr_i;
            wb_dat_o    <= cmd_dat_i;
            wb_sel_o    <= cmd_sel_i;
            retry_q     <= 8'd0;
            tmo_q       <= 16'd0;
            cmd_ready_o <= 1'b0;
            wb_cyc_o    <= 1'b1;
            wb_stb_o    <= 1'b1;
            state_q     <= StBus;
          end
        end

        StBus: begin
          if (bus_active) begin
            // err > rty > ack; any termination beats a same-cycle timeout.
            if (wb_err_i) begin
              wb_cyc_o      <= 1'b0;
              wb_stb_o      <= 1'b0;
              rsp_dat_o     <= 32'd0;
              rsp_status_o  <= StatusErr;
              rsp_retries_o <= retry_q;
              rsp_valid_o   <= 1'b1;
              state_q       <= StResp;
            end else if (wb_rty_i) begin
              retry_q  <= retry_inc;
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              if (retry_allowed) begin
                state_q <= StBackoff;
              end else begin
                rsp_dat_o     <= 32'd0;
                rsp_status_o  <= StatusRtyExh;
                rsp_retries_o <= retry_inc;
                rsp_valid_o   <= 1'b1;
                state_q       <= StResp;
              end
            end else if (wb_ack_i) begin
              wb_cyc_o      <= 1'b0;
              wb_stb_o      <= 1'b0;
              rsp_dat_o     <= wb_we_o ? 32'd0 : wb_dat_i;
              rsp_status_o  <= StatusOk;
              rsp_retries_o <= retry_q;
              rsp_valid_o   <= 1'b1;
              state_q       <= StResp;
            end else if (tmo_q == TmoLast) begin
              wb_cyc_o      <= 1'b0;
              wb_stb_o      <= 1'b0;
              rsp_dat_o     <= 32'd0;
              rsp_status_o  <= StatusTimeout;
              rsp_retries_o <= retry_q;
              rsp_valid_o   <= 1'b1;
              state_q       <= StResp;
            end else begin
              tmo_q <= tmo_q + 16'd1;
            end
          end
        end

        StBackoff: begin
          // One idle bus cycle, then a fresh attempt with the same command.
          tmo_q    <= 16'd0;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          state_q  <= StBus;
        end

        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            state_q     <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fw_interface_master.sv
// Scoreboard bench for fw_interface_master (TIMEOUT=16, MAX_RETRY=3).
// The driver pushes the expected response and bus statistics for each command;
// a negedge monitor plays the Wishbone responder, gathers bus statistics and
// pops/compares at every response handshake.
module tb_fw_interface_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic [7:0]  rsp_retries;
  logic [31:0] wb_adr, wb_dat_o;
  logic [3:0]  wb_sel;
  logic        wb_we, wb_cyc, wb_stb;
  logic [2:0]  wb_cti;
  logic [1:0]  wb_bte;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack = 1'b0, wb_err = 1'b0, wb_rty = 1'b0;

  fw_interface_master #(.TIMEOUT(16), .MAX_RETRY(3)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_ready_o   (cmd_ready),
    .cmd_we_i      (cmd_we),
    .cmd_adr_i     (cmd_adr),
    .cmd_dat_i     (cmd_dat),
    .cmd_sel_i     (cmd_sel),
    .rsp_valid_o   (rsp_valid),
    .rsp_ready_i   (rsp_ready),
    .rsp_dat_o     (rsp_dat),
    .rsp_status_o  (rsp_status),
    .rsp_retries_o (rsp_retries),
    .wb_adr_o      (wb_adr),
    .wb_dat_o      (wb_dat_o),
    .wb_sel_o      (wb_sel),
    .wb_we_o       (wb_we),
    .wb_cyc_o      (wb_cyc),
    .wb_stb_o      (wb_stb),
    .wb_cti_o      (wb_cti),
    .wb_bte_o      (wb_bte),
    .wb_dat_i      (wb_dat_i),
    .wb_ack_i      (wb_ack),
    .wb_err_i      (wb_err),
    .wb_rty_i      (wb_rty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic [1:0]  status;
    logic [7:0]  retries;
    int          attempts;
    int          cyc;
    int          lat;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass = 0;

  // Responder configuration for the command in flight.
  int          resp_cycle = 0;  // cycle of an attempt that terminates; 0 = silent
  int          rty_n = 0;       // leading attempts answered with rty alone
  bit          rty_all = 1'b0;  // every attempt answered with rty alone
  int          kind = 0;        // 0 ack, 1 err, 2 err+ack, 3 rty+ack, 4 err+rty
  logic [31:0] rd_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor / responder state.
  bit          active = 1'b0;
  bit          prev_cyc = 1'b0;
  bit          seen_valid = 1'b0;
  int          lat, lat_at, attempts, cyc_in, cyc_total, gap_cnt, gap_sum;
  bit          bus_bad, unstable, ready_bad;
  logic [31:0] snap_dat;
  logic [1:0]  snap_status;
  logic [7:0]  snap_retries;
  exp_t        cur;

  always @(negedge clk) begin
    wb_dat_i = rd_data;
    wb_ack = 1'b0;
    wb_err = 1'b0;
    wb_rty = 1'b0;
    if (rst) begin
      active   = 1'b0;
      prev_cyc = 1'b0;
    end else begin
      if (active) begin
        lat++;
        if (wb_cyc && wb_stb) begin
          if (!prev_cyc) begin
            attempts++;
            if (attempts > 1) gap_sum += gap_cnt;
            gap_cnt = 0;
            cyc_in  = 0;
          end
          cyc_in++;
          cyc_total++;
          if (q.size() > 0) begin
            if (wb_adr !== q[0].adr || wb_we !== q[0].we || wb_sel !== q[0].sel ||
                (q[0].we && wb_dat_o !== q[0].wdat)) bus_bad = 1'b1;
          end
          if (resp_cycle != 0 && cyc_in == resp_cycle) begin
            if (rty_all || attempts <= rty_n) begin
              wb_rty = 1'b1;
            end else begin
              wb_ack = (kind == 0 || kind == 2 || kind == 3);
              wb_err = (kind == 1 || kind == 2 || kind == 4);
              wb_rty = (kind == 3 || kind == 4);
            end
          end
        end else if (attempts > 0) begin
          gap_cnt++;
        end
        if (rsp_valid) begin
          if (!seen_valid) begin
            seen_valid   = 1'b1;
            lat_at       = lat;
            snap_dat     = rsp_dat;
            snap_status  = rsp_status;
            snap_retries = rsp_retries;
          end else if (rsp_dat !== snap_dat || rsp_status !== snap_status ||
                       rsp_retries !== snap_retries) begin
            unstable = 1'b1;
          end
          if (cmd_ready) ready_bad = 1'b1;
          if (rsp_ready) begin
            if (q.size() == 0) begin
              check("response with empty scoreboard", 32'd1, 32'd0);
            end else begin
              cur = q.pop_front();
              check("rsp_dat", rsp_dat, cur.dat);
              check("rsp_status", {30'd0, rsp_status}, {30'd0, cur.status});
              check("rsp_retries", {24'd0, rsp_retries}, {24'd0, cur.retries});
              check("attempts", attempts, cur.attempts);
              check("cyc_stb_cycles", cyc_total, cur.cyc);
              check("backoff_gap_total", gap_sum, cur.attempts - 1);
              check("latency", lat_at, cur.lat);
              check("bus_fields", {31'd0, bus_bad}, 32'd0);
              check("rsp_stable", {31'd0, unstable}, 32'd0);
              check("cmd_ready_low_in_resp", {31'd0, ready_bad}, 32'd0);
            end
            active = 1'b0;
          end
        end
      end else if (rsp_valid && rsp_ready) begin
        check("unexpected response", 32'd1, 32'd0);
      end
      prev_cyc = wb_cyc & wb_stb;
      // Command will be taken at the coming edge: arm per-command statistics.
      if (cmd_valid && cmd_ready) begin
        active     = 1'b1;
        seen_valid = 1'b0;
        lat        = 0;
        attempts   = 0;
        cyc_in     = 0;
        cyc_total  = 0;
        gap_cnt    = 0;
        gap_sum    = 0;
        bus_bad    = 1'b0;
        unstable   = 1'b0;
        ready_bad  = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel);
    int n;
    @(posedge clk);
    #1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = wdat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("cmd accept wait expired", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, input int rcyc, input int rn, input bit rall,
                         input int knd, input logic [31:0] rdata, input logic [1:0] st,
                         input logic [31:0] edat, input logic [7:0] eret, input int eatt,
                         input int ecyc, input int elat, input int hold);
    exp_t e;
    int n;
    resp_cycle = rcyc;
    rty_n      = rn;
    rty_all    = rall;
    kind       = knd;
    rd_data    = rdata;
    e.dat = edat; e.status = st; e.retries = eret; e.attempts = eatt;
    e.cyc = ecyc; e.lat = elat; e.we = we; e.adr = adr; e.wdat = wdat; e.sel = sel;
    q.push_back(e);
    send_cmd(we, adr, wdat, sel);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 200);
    if (n >= 200) begin
      check("response wait expired", 32'd1, 32'd0);
      void'(q.pop_front());
    end else begin
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
    end
  endtask

  int vcount;

  initial begin
    // Reset state.
    #1;
    check("reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("cti_bte", {27'd0, wb_cti, wb_bte}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("cmd_ready before first clock", {31'd0, cmd_ready}, 32'd0);
    @(posedge clk);
    #1 check("cmd_ready after first clock", {31'd0, cmd_ready}, 32'd1);

    //     we adr           wdat          sel  rc rn ra k  rdata         st edat          rt at cy lt hold
    run_cmd(1, 32'h40000010, 32'hDEADBEEF, 4'hF, 1, 0, 0, 0, 32'hCAFEF00D, 0, 32'h0,        0, 1, 1, 2, 0);
    run_cmd(0, 32'h40000004, 32'h0,        4'hF, 4, 0, 0, 0, 32'h12345678, 0, 32'h12345678, 0, 1, 4, 5, 0);
    run_cmd(0, 32'h40000008, 32'h0,        4'hF, 1, 2, 0, 0, 32'h11112222, 0, 32'h11112222, 2, 3, 3, 6, 0);
    run_cmd(0, 32'h4000000C, 32'h0,        4'hF, 1, 0, 1, 0, 32'h33334444, 2, 32'h0,        4, 4, 4, 8, 0);
    run_cmd(0, 32'h40000020, 32'h0,        4'hF, 0, 0, 0, 0, 32'h55556666, 3, 32'h0,        0, 1, 16, 17, 0);
    run_cmd(0, 32'h40000024, 32'h0,        4'h3, 16, 0, 0, 0, 32'h77778888, 0, 32'h77778888, 0, 1, 16, 17, 0);
    run_cmd(0, 32'h40000028, 32'h0,        4'hF, 2, 0, 0, 2, 32'h9999AAAA, 1, 32'h0,        0, 1, 2, 3, 5);
    run_cmd(1, 32'h40000030, 32'h0BADF00D, 4'h5, 1, 0, 0, 3, 32'h0,        2, 32'h0,        4, 4, 4, 8, 0);
    run_cmd(1, 32'h40000034, 32'h00C0FFEE, 4'hC, 1, 1, 0, 4, 32'h0,        1, 32'h0,        1, 2, 2, 4, 0);

    // Reset two cycles into a waiting read: in-flight command is dropped.
    resp_cycle = 0;
    rty_n = 0;
    rty_all = 1'b0;
    kind = 0;
    q.push_back('{dat: 32'h0, status: 2'd3, retries: 8'd0, attempts: 1, cyc: 16, lat: 17,
                  we: 1'b0, adr: 32'h40000038, wdat: 32'h0, sel: 4'hF});
    send_cmd(0, 32'h40000038, 32'h0, 4'hF);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("mid-cycle reset cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
    check("mid-cycle reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid-cycle reset cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("mid-cycle reset wb_adr", wb_adr, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("cmd_ready right after release", {31'd0, cmd_ready}, 32'd0);
    vcount = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid || wb_cyc) vcount++;
    end
    check("no activity after reset", vcount, 0);

    run_cmd(1, 32'h40000040, 32'h01020304, 4'h3, 2, 0, 0, 0, 32'hFFFFFFFF, 0, 32'h0, 0, 1, 2, 3, 0);

    repeat (3) @(posedge clk);
    check("scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
